lsu_bus_port: RTL and testbench
===============================

// Module: lsu_bus_port
// PURPOSE
//  Memory-side responder for the controller's memw/memwidth/memsext outputs.
//  Converts one core load/store into a single word-aligned bus transaction:
//  byte lanes, write strobes, store replication, load extraction and sign-extension.
//  Stalls the core while the transaction is outstanding.
//  Reports misaligned/invalid accesses and response timeouts.
// PARAMETERS
//  TIMEOUT  255  max cycles in RESP waiting for bus_rvalid before err; >=1
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  reset      in   1   synchronous, active-high
//  req        in   1   core presents a memory op; held, with fields, while stall=1
//  memw       in   1   1=store, 0=load
//  memwidth   in   2   0=byte 1=half 2=word 3=invalid
//  memsext    in   1   load sign-extend (1) / zero-extend (0)
//  addr       in   32  byte address (ALU result)
//  wdata      in   32  store data, right-justified
//  stall      out  1   comb: req && state!=DONE
//  rdata      out  32  formatted load data; valid in DONE
//  err        out  1   in DONE: misaligned/invalid width or timeout
//  bus_valid  out  1   request valid; held until bus_ready
//  bus_we     out  1   write enable
//  bus_addr   out  32  {addr[31:2],2'b00}
//  bus_wdata  out  32  lane-replicated store data
//  bus_wstrb  out  4   byte strobes; 0000 on loads
//  bus_ready  in   1   bus accepts request when valid&&ready
//  bus_rvalid in   1   response/ack, one cycle; carries bus_rdata on loads
//  bus_rdata  in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE; bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, rdata and err all 0.
//  Reset mid-transaction: abandon, IDLE next cycle; bus_valid low next cycle.
//  FSM IDLE->ADDR->RESP->DONE->IDLE:
//   IDLE: req=1 latches addr[1:0], memw, memwidth, memsext.
//    Misaligned (half & addr[0]; word & addr[1:0]!=0; width 3) -> DONE, err=1, rdata=0, no bus op.
//    Otherwise -> ADDR; bus_* registered.
//   ADDR: bus_valid=1, outputs stable; valid&&ready -> RESP; bus_valid=0 next cycle.
//   RESP: timeout counter from 0. bus_rvalid -> DONE, err=0.
//    Load: rdata computed from bus_rdata. Counter reaching TIMEOUT -> DONE, err=1, rdata=0.
//   DONE: stall=0 for exactly one cycle -> IDLE. rdata/err hold until next DONE.
//  Store lanes (o=addr[1:0]):
//   byte: wdata={4{wdata[7:0]}}, wstrb=0001<<o
//   half: wdata={2{wdata[15:0]}}, wstrb=0011<<o
//   word: wdata=wdata, wstrb=1111
//  Load extract: byte=rdata[8*o+:8]; half=rdata[8*o+:16]; word=rdata; ext per memsext.
//  bus_rvalid outside RESP is ignored. bus_ready outside ADDR is ignored.
//  Min latency: req cycle 0, bus_valid cycle 1; ready@1, rvalid@2 -> DONE@3 (3 stall cycles).
//  Misaligned: DONE@1 (1 stall cycle).
//  req=0 in IDLE: no activity, stall=0.
// TESTING
//  1 LB addr=0x1003 sext, rdata=0x80FF_FF00 -> bus_addr=0x1000, wstrb=0000, rdata=0xFFFF_FF80, err=0
//  2 LHU addr=0x2002, rdata=0xBEEF_1234 -> rdata=0x0000_BEEF
//  3 SB addr=0x3001, wdata=0x0000_00AB -> bus_wdata=0xABAB_ABAB, wstrb=0010, bus_we=1
//  4 SW addr=0x4002 -> no bus_valid, DONE after 1 stall, err=1
//  5 ready low 5 cycles, then rvalid late -> bus_valid/addr stable throughout; stall until DONE
//  6 TIMEOUT=4, no rvalid -> err=1 after 4 RESP cycles; reset asserted in ADDR -> bus_valid=0 next cycle, IDLE

Source files
------------

// File: rtl/lsu_bus_port.sv
// ============================================================================
// Module      : lsu_bus_port
// Description : Memory-side responder for the core's load/store unit. Turns
//               one core load/store into a single word-aligned bus
//               transaction. It generates the byte lanes, write strobes and
//               store replication, and extracts and extends load data. The
//               core is stalled while the transaction is outstanding.
//               Misaligned or invalid accesses and response timeouts are
//               reported through err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high
//   req        in   1   core memory op request (held with fields while stall)
//   memw       in   1   1 = store, 0 = load
//   memwidth   in   2   0 = byte, 1 = half, 2 = word, 3 = invalid
//   memsext    in   1   load sign-extend (1) / zero-extend (0)
//   addr       in   32  byte address
//   wdata      in   32  store data, right-justified
//   stall      out  1   req && state != DONE
//   rdata      out  32  formatted load data, valid in DONE
//   err        out  1   misaligned/invalid access or timeout, valid in DONE
//   bus_valid  out  1   bus request valid, held until bus_ready
//   bus_we     out  1   bus write enable
//   bus_addr   out  32  word-aligned bus address
//   bus_wdata  out  32  lane-replicated store data
//   bus_wstrb  out  4   byte strobes (0000 on loads)
//   bus_ready  in   1   request accepted when bus_valid && bus_ready
//   bus_rvalid in   1   one-cycle response / write acknowledge
//   bus_rdata  in   32  read word
// ============================================================================
`default_nettype none

module lsu_bus_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memw,
    input  logic [1:0]  memwidth,
    input  logic        memsext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    // Counter wide enough to hold TIMEOUT-1.
    localparam int unsigned C_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] C_W_BYTE = 2'd0;
    localparam logic [1:0] C_W_HALF = 2'd1;
    localparam logic [1:0] C_W_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state_q,     w_state_d;
    logic [1:0]         r_off_q,       w_off_d;
    logic               r_we_q,        w_we_d;
    logic [1:0]         r_width_q,     w_width_d;
    logic               r_sext_q,      w_sext_d;
    logic [C_CNT_W-1:0] r_cnt_q,       w_cnt_d;
    logic [31:0]        r_rdata_q,     w_rdata_d;
    logic               r_err_q,       w_err_d;
    logic               r_bus_valid_q, w_bus_valid_d;
    logic [31:0]        r_bus_addr_q,  w_bus_addr_d;
    logic [31:0]        r_bus_wdata_q, w_bus_wdata_d;
    logic [3:0]         r_bus_wstrb_q, w_bus_wstrb_d;

    // ------------------------------------------------------------------
    // Request decode (from live core inputs, used only when leaving IDLE)
    // ------------------------------------------------------------------
    logic        w_misaligned;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;

    always_comb begin
        w_misaligned = 1'b0;
        case (memwidth)
            C_W_BYTE: w_misaligned = 1'b0;
            C_W_HALF: w_misaligned = addr[0];
            C_W_WORD: w_misaligned = (addr[1:0] != 2'b00);
            default:  w_misaligned = 1'b1;
        endcase
    end

    // Stores replicate the datum across every lane it could occupy so the
    // strobes alone select the target bytes.
    always_comb begin
        w_st_wdata = wdata;
        w_st_wstrb = 4'b1111;
        case (memwidth)
            C_W_BYTE: begin
                w_st_wdata = {4{wdata[7:0]}};
                w_st_wstrb = 4'b0001 << addr[1:0];
            end
            C_W_HALF: begin
                w_st_wdata = {2{wdata[15:0]}};
                w_st_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                w_st_wdata = wdata;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction: shift the addressed lane down to bit 0, then extend.
    // ------------------------------------------------------------------
    logic [31:0] w_ld_shift;
    logic [31:0] w_ld_data;

    always_comb begin
        w_ld_shift = bus_rdata >> {r_off_q, 3'b000};
        w_ld_data  = w_ld_shift;
        case (r_width_q)
            C_W_BYTE: w_ld_data = r_sext_q ? {{24{w_ld_shift[7]}}, w_ld_shift[7:0]}
                                           : {24'h0, w_ld_shift[7:0]};
            C_W_HALF: w_ld_data = r_sext_q ? {{16{w_ld_shift[15]}}, w_ld_shift[15:0]}
                                           : {16'h0, w_ld_shift[15:0]};
            default:  w_ld_data = w_ld_shift;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_off_d       = r_off_q;
        w_we_d        = r_we_q;
        w_width_d     = r_width_q;
        w_sext_d      = r_sext_q;
        w_cnt_d       = r_cnt_q;
        w_rdata_d     = r_rdata_q;
        w_err_d       = r_err_q;
        w_bus_valid_d = r_bus_valid_q;
        w_bus_addr_d  = r_bus_addr_q;
        w_bus_wdata_d = r_bus_wdata_q;
        w_bus_wstrb_d = r_bus_wstrb_q;

        case (r_state_q)
            S_IDLE: begin
                if (req) begin
                    w_off_d   = addr[1:0];
                    w_we_d    = memw;
                    w_width_d = memwidth;
                    w_sext_d  = memsext;
                    if (w_misaligned) begin
                        // Rejected without touching the bus.
                        w_state_d = S_DONE;
                        w_err_d   = 1'b1;
                        w_rdata_d = 32'h0;
                    end else begin
                        w_state_d     = S_ADDR;
                        w_bus_valid_d = 1'b1;
                        w_bus_addr_d  = {addr[31:2], 2'b00};
                        w_bus_wdata_d = memw ? w_st_wdata : 32'h0;
                        w_bus_wstrb_d = memw ? w_st_wstrb : 4'b0000;
                    end
                end
            end

            S_ADDR: begin
                if (bus_ready) begin
                    w_state_d     = S_RESP;
                    w_bus_valid_d = 1'b0;
                    w_cnt_d       = '0;
                end
            end

            S_RESP: begin
                // A response arriving on the last allowed cycle still wins.
                if (bus_rvalid) begin
                    w_state_d = S_DONE;
                    w_err_d   = 1'b0;
                    w_rdata_d = r_we_q ? 32'h0 : w_ld_data;
                end else if (r_cnt_q == C_CNT_LAST) begin
                    w_state_d = S_DONE;
                    w_err_d   = 1'b1;
                    w_rdata_d = 32'h0;
                end else begin
                    w_cnt_d = r_cnt_q + C_CNT_W'(1);
                end
            end

            S_DONE: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_IDLE;
            r_off_q       <= 2'b00;
            r_we_q        <= 1'b0;
            r_width_q     <= 2'b00;
            r_sext_q      <= 1'b0;
            r_cnt_q       <= '0;
            r_rdata_q     <= 32'h0;
            r_err_q       <= 1'b0;
            r_bus_valid_q <= 1'b0;
            r_bus_addr_q  <= 32'h0;
            r_bus_wdata_q <= 32'h0;
            r_bus_wstrb_q <= 4'b0000;
        end else begin
            r_state_q     <= w_state_d;
            r_off_q       <= w_off_d;
            r_we_q        <= w_we_d;
            r_width_q     <= w_width_d;
            r_sext_q      <= w_sext_d;
            r_cnt_q       <= w_cnt_d;
            r_rdata_q     <= w_rdata_d;
            r_err_q       <= w_err_d;
            r_bus_valid_q <= w_bus_valid_d;
            r_bus_addr_q  <= w_bus_addr_d;
            r_bus_wdata_q <= w_bus_wdata_d;
            r_bus_wstrb_q <= w_bus_wstrb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall     = req && (r_state_q != S_DONE);
    assign rdata     = r_rdata_q;
    assign err       = r_err_q;
    assign bus_valid = r_bus_valid_q;
    assign bus_we    = r_we_q;
    assign bus_addr  = r_bus_addr_q;
    assign bus_wdata = r_bus_wdata_q;
    assign bus_wstrb = r_bus_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_port.sv
// ============================================================================
// Module      : tb_lsu_bus_port
// Description : Self-checking bench for lsu_bus_port. A table of load/store
//               vectors is driven through a small bus responder; expected
//               completion results are queued at issue and popped at DONE.
//               Hand-written sequences cover reset and mid-transaction reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_port;

    localparam int unsigned TIMEOUT = 4;
    localparam int          NV      = 14;

    logic        clk;
    logic        reset;
    logic        req;
    logic        memw;
    logic [1:0]  memwidth;
    logic        memsext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    lsu_bus_port #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .memw       (memw),
        .memwidth   (memwidth),
        .memsext    (memsext),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .err        (err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  wd;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wdat;
        logic [31:0] brd;        // word returned by the responder
        int          rw;         // cycles bus_ready is held low
        int          rv;         // RESP cycle index carrying rvalid (large = never)
        logic [31:0] e_baddr;
        logic [31:0] e_bwdata;
        logic [3:0]  e_wstrb;
        logic        e_we;
        int          e_vcyc;     // cycles bus_valid is high
        int          e_stalls;   // cycles stall is high
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs [NV];
    exp_t exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic w, input logic [1:0] wd,
                                input logic sx, input logic [31:0] a, input logic [31:0] wdat,
                                input logic [31:0] brd, input int rw, input int rv,
                                input logic [31:0] eba, input logic [31:0] ebw,
                                input logic [3:0] es, input logic ewe, input int evc,
                                input int est, input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.name = nm; v.w = w; v.wd = wd; v.sx = sx; v.a = a; v.wdat = wdat;
        v.brd = brd; v.rw = rw; v.rv = rv; v.e_baddr = eba; v.e_bwdata = ebw;
        v.e_wstrb = es; v.e_we = ewe; v.e_vcyc = evc; v.e_stalls = est;
        v.e_rdata = erd; v.e_err = eerr;
        return v;
    endfunction

    // Issue one op, act as the bus slave, and check the completion.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc;
        int   stalls;
        int   vcyc;
        int   resp_cnt;
        bit   in_resp;
        bit   done;
        @(negedge clk);
        req        = 1'b1;
        memw       = v.w;
        memwidth   = v.wd;
        memsext    = v.sx;
        addr       = v.a;
        wdata      = v.wdat;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = v.brd;
        e.rdata    = v.e_rdata;
        e.err      = v.e_err;
        exp_q.push_back(e);
        cyc = 0; stalls = 0; vcyc = 0; resp_cnt = 0; in_resp = 0; done = 0;
        while (!done && cyc < 60) begin
            #1;
            if (stall === 1'b0) begin
                done = 1;
                if (exp_q.size() == 0) begin
                    chk({v.name, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk({v.name, "_rdata"}, rdata, e.rdata);
                    chk({v.name, "_err"}, {31'h0, err}, {31'h0, e.err});
                end
                chk({v.name, "_stalls"}, stalls, v.e_stalls);
                chk({v.name, "_valid_cycles"}, vcyc, v.e_vcyc);
                chk({v.name, "_done_valid"}, {31'h0, bus_valid}, 32'h0);
            end else begin
                stalls++;
                if (bus_valid === 1'b1) begin
                    vcyc++;
                    chk({v.name, "_bus_addr"}, bus_addr, v.e_baddr);
                    chk({v.name, "_bus_we"}, {31'h0, bus_we}, {31'h0, v.e_we});
                    chk({v.name, "_bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.e_wstrb});
                    if (v.w)
                        chk({v.name, "_bus_wdata"}, bus_wdata, v.e_bwdata);
                end
                bus_rvalid = in_resp && (resp_cnt == v.rv);
                bus_ready  = (bus_valid === 1'b1) && (vcyc > v.rw);
                if (in_resp)
                    resp_cnt++;
                if (bus_valid === 1'b1 && bus_ready)
                    in_resp = 1;
                @(negedge clk);
                cyc++;
            end
        end
        if (!done)
            chk({v.name, "_done_timeout"}, 32'd0, 32'd1);
        req        = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        // Idle with stray ready/rvalid: results must hold, nothing starts.
        @(negedge clk);
        bus_rvalid = 1'b1;
        bus_ready  = 1'b1;
        bus_rdata  = 32'h5A5A_A5A5;
        @(negedge clk);
        #1;
        chk({v.name, "_hold_rdata"}, rdata, v.e_rdata);
        chk({v.name, "_hold_err"}, {31'h0, err}, {31'h0, v.e_err});
        chk({v.name, "_idle_valid"}, {31'h0, bus_valid}, 32'h0);
        chk({v.name, "_idle_stall"}, {31'h0, stall}, 32'h0);
        bus_rvalid = 1'b0;
        bus_ready  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           name    w   wd    sx  addr          wdata         bus_rdata     rw rv   baddr         bwdata        wstrb    we  vc st  rdata         err
        vecs[0]  = mk("lb_s",  0, 2'd0, 1, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 0, 0,  32'h0000_1000, 32'h0,        4'b0000, 0, 1, 3,  32'hFFFF_FF80, 0);
        vecs[1]  = mk("lhu",   0, 2'd1, 0, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 0,  32'h0000_2000, 32'h0,        4'b0000, 0, 1, 3,  32'h0000_BEEF, 0);
        vecs[2]  = mk("sb",    1, 2'd0, 0, 32'h0000_3001, 32'h0000_00AB, 32'h0,        0, 0,  32'h0000_3000, 32'hABAB_ABAB, 4'b0010, 1, 1, 3,  32'h0,        0);
        vecs[3]  = mk("sw_mis",1, 2'd2, 0, 32'h0000_4002, 32'h1111_2222, 32'h0,        0, 0,  32'h0,        32'h0,        4'b0000, 1, 0, 1,  32'h0,        1);
        vecs[4]  = mk("lw_slow",0,2'd2, 0, 32'h0000_5000, 32'h0,        32'h1234_5678, 5, 2,  32'h0000_5000, 32'h0,        4'b0000, 0, 6, 10, 32'h1234_5678, 0);
        vecs[5]  = mk("lw_tmo",0, 2'd2, 0, 32'h0000_6000, 32'h0,        32'h7777_7777, 0, 999,32'h0000_6000, 32'h0,        4'b0000, 0, 1, 6,  32'h0,        1);
        vecs[6]  = mk("lw_last",0,2'd2, 0, 32'h0000_6004, 32'h0,        32'hCAFE_F00D, 0, 3,  32'h0000_6004, 32'h0,        4'b0000, 0, 1, 6,  32'hCAFE_F00D, 0);
        vecs[7]  = mk("lbu0",  0, 2'd0, 0, 32'h0000_7000, 32'h0,        32'h1234_56F5, 0, 0,  32'h0000_7000, 32'h0,        4'b0000, 0, 1, 3,  32'h0000_00F5, 0);
        vecs[8]  = mk("lh_s",  0, 2'd1, 1, 32'h0000_7100, 32'h0,        32'hAAAA_8001, 0, 0,  32'h0000_7100, 32'h0,        4'b0000, 0, 1, 3,  32'hFFFF_8001, 0);
        vecs[9]  = mk("sh",    1, 2'd1, 0, 32'h0000_7202, 32'h1234_CDEF, 32'h0,        0, 0,  32'h0000_7200, 32'hCDEF_CDEF, 4'b1100, 1, 1, 3,  32'h0,        0);
        vecs[10] = mk("sw",    1, 2'd2, 0, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0,        2, 1,  32'h0000_8000, 32'hDEAD_BEEF, 4'b1111, 1, 3, 6,  32'h0,        0);
        vecs[11] = mk("w3",    0, 2'd3, 0, 32'h0000_9000, 32'h0,        32'h0,        0, 0,  32'h0,        32'h0,        4'b0000, 0, 0, 1,  32'h0,        1);
        vecs[12] = mk("lh_mis",0, 2'd1, 1, 32'h0000_9001, 32'h0,        32'h0,        0, 0,  32'h0,        32'h0,        4'b0000, 0, 0, 1,  32'h0,        1);
        vecs[13] = mk("lb_s2", 1'b0,2'd0,1, 32'h0000_9102, 32'h0,        32'h007F_0000, 0, 0,  32'h0000_9100, 32'h0,        4'b0000, 0, 1, 3,  32'h0000_007F, 0);

        reset = 1'b1; req = 1'b0; memw = 1'b0; memwidth = 2'd0; memsext = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst_we",    {31'h0, bus_we},    32'h0);
        chk("rst_addr",  bus_addr,           32'h0);
        chk("rst_wdata", bus_wdata,          32'h0);
        chk("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("rst_rdata", rdata,              32'h0);
        chk("rst_err",   {31'h0, err},       32'h0);
        reset = 1'b0;

        // req low: nothing happens.
        repeat (3) @(negedge clk);
        #1;
        chk("idle_stall", {31'h0, stall},     32'h0);
        chk("idle_valid", {31'h0, bus_valid}, 32'h0);

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i]);

        // Reset while in ADDR: request abandoned.
        @(negedge clk);
        req = 1'b1; memw = 1'b0; memwidth = 2'd2; memsext = 1'b0;
        addr = 32'h0000_A000; bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_in_addr", {31'h0, bus_valid}, 32'h1);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", {31'h0, bus_valid}, 32'h0);
        chk("mid_rst_addr",  bus_addr,           32'h0);
        chk("mid_rst_err",   {31'h0, err},       32'h0);
        chk("mid_rst_stall", {31'h0, stall},     32'h0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_valid", {31'h0, bus_valid}, 32'h0);

        // Normal traffic resumes after the abandoned request.
        run_vec(vecs[0]);
        run_vec(vecs[9]);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
